pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter WAIT_LIMIT, default 15: maximum counted consecutive instruction-memory not-ready cycles before fault.
REQ-002 Parameter CNT_W, default 16: width of the stall performance counter.
REQ-003 Port clk  in  1: single clock; all state updates on the rising edge.
REQ-004 Port clrn  in  1: reset, asynchronous and active-low.
REQ-005 Port id_rs, id_rt  in  5 each: source register numbers of the instruction in ID.
REQ-006 Port id_use_rs, id_use_rt  in  1 each: the ID instruction reads rs or rt, respectively.
REQ-007 Port ex_rn  in  5: destination register of the instruction in EX.
REQ-008 Port ex_wreg, ex_m2reg  in  1 each: EX instruction writes a register / is a load.
REQ-009 Port br_taken  in  1: branch or jump resolved taken in ID this cycle.
REQ-010 Port imem_ready  in  1: instruction memory delivers a valid word this cycle.
REQ-011 Port wpcir  out  1: write enable for the PC and the IF/ID register.
REQ-012 Port if_flush  out  1: IF/ID loads NOP (32'h0) at the next edge.
REQ-013 Port id_bubble  out  1: ID/EX control fields are zeroed at the next edge.
REQ-014 Port fault  out  1: sticky instruction-fetch timeout flag.
REQ-015 Port stall_count  out  CNT_W: saturating count of stalled cycles.
REQ-016 Port state  out  2: current FSM state encoding.

Function
REQ-017 Load-use hazard lu SHALL be 1 iff ex_m2reg & ex_wreg & (ex_rn != 0) & ((id_use_rs & ex_rn == id_rs) | (id_use_rt & ex_rn == id_rt)).
REQ-018 FSM states SHALL be RUN=2'd0, STALL=2'd1, WAIT=2'd2, FAULT=2'd3.
REQ-019 Outside FAULT, outputs SHALL be combinational: wpcir = imem_ready & ~lu; id_bubble = lu | ~imem_ready; if_flush = br_taken & imem_ready & ~lu.
REQ-020 Priority SHALL be: fetch wait, then load-use, then branch flush; a taken branch during lu SHALL be ignored, because the ID instruction re-evaluates it next cycle.
REQ-021 In FAULT, outputs SHALL be wpcir=0, id_bubble=1, if_flush=0, independent of inputs.
REQ-022 RUN and STALL transitions: ~imem_ready goes to WAIT with wait_cnt=1; else lu goes to STALL; else the FSM goes to RUN.
REQ-023 WAIT transitions: imem_ready goes to RUN with wait_cnt=0; ~imem_ready with wait_cnt==WAIT_LIMIT goes to FAULT; otherwise wait_cnt increments and the FSM stays in WAIT.
REQ-024 Result: WAIT_LIMIT+1 consecutive not-ready cycles produce FAULT; ready rising on the last allowed cycle returns to RUN.
REQ-025 FAULT SHALL be terminal until clrn is asserted; fault = (state == FAULT).
REQ-026 stall_count SHALL increment by 1 each edge where wpcir==0 and state!=FAULT, saturating at all-ones.
REQ-027 The lu compare SHALL treat register 0 as never hazardous, even when ex_wreg=1.

Reset
REQ-028 clrn low SHALL immediately force state=RUN, wait_cnt=0, stall_count=0, fault=0.
REQ-029 During reset, outputs SHALL follow REQ-019 with state RUN.
REQ-030 Reset asserted mid-WAIT or in FAULT SHALL abandon the timeout; the first post-reset cycle is in RUN.

Structure
REQ-031 Package pipe_ctrl_pkg SHALL hold the state enum, the WAIT_LIMIT default and the CNT_W default.
REQ-032 The lu comparator SHALL be a combinational sub-module, hazard_detect.
REQ-033 wait_cnt width SHALL be $clog2(WAIT_LIMIT+1).

Verification
REQ-034 ex_m2reg=1, ex_wreg=1, ex_rn=5, id_rs=5, id_use_rs=1, imem_ready=1 -> wpcir=0, id_bubble=1, next state STALL, stall_count +1.
REQ-035 Same stimulus as REQ-034 with ex_rn=0 -> wpcir=1, id_bubble=0, state stays RUN.
REQ-036 br_taken=1 with no hazard -> if_flush=1, wpcir=1; br_taken=1 with lu=1 -> if_flush=0.
REQ-037 imem_ready=0 for 15 cycles then 1 -> state WAIT then RUN, fault=0, stall_count=15.
REQ-038 imem_ready=0 for 16 cycles -> state=3, fault=1, wpcir=0; pulse clrn low -> state=0, fault=0, stall_count=0.
REQ-039 Force stall_count to 16'hFFFE, then 3 stall cycles -> stall_count holds at 16'hFFFF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int WAIT_LIMIT_DEF = 15;
    localparam int CNT_W_DEF      = 16;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_WAIT  = 2'd2,
        S_FAULT = 2'd3
    } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator between the ID instruction and a load in EX.
module hazard_detect (
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic [4:0] ex_rn,
    input  logic       ex_wreg,
    input  logic       ex_m2reg,
    output logic       lu
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = id_use_rs & (ex_rn == id_rs);
    assign rt_hit = id_use_rt & (ex_rn == id_rt);

    // r0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign lu = ex_m2reg & ex_wreg & (ex_rn != 5'd0) & (rs_hit | rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: load-use interlock, branch flush and
// instruction-fetch timeout with a saturating stall counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = WAIT_LIMIT_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       ex_rn,
    input  logic             ex_wreg,
    input  logic             ex_m2reg,
    input  logic             br_taken,
    input  logic             imem_ready,
    output logic             wpcir,
    output logic             if_flush,
    output logic             id_bubble,
    output logic             fault,
    output logic [CNT_W-1:0] stall_count,
    output logic [1:0]       state
);

    localparam int WCW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(WAIT_LIMIT);

    state_e           state_q, state_d;
    logic [WCW-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0] stall_q;
    logic             lu;

    hazard_detect u_hazard (
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .ex_rn     (ex_rn),
        .ex_wreg   (ex_wreg),
        .ex_m2reg  (ex_m2reg),
        .lu        (lu)
    );

    // Handshake: imem_ready is the valid for the fetched word; wpcir is the
    // pipeline's accept. A word is consumed only on an edge where both are 1.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        wpcir     = imem_ready & ~lu;
        id_bubble = lu | ~imem_ready;
        if_flush  = br_taken & imem_ready & ~lu;

        case (state_q)
            S_RUN, S_STALL: begin
                if (!imem_ready) begin
                    state_d = S_WAIT;
                    wait_d  = WCW'(1);
                end else if (lu) begin
                    state_d = S_STALL;
                    wait_d  = '0;
                end else begin
                    state_d = S_RUN;
                    wait_d  = '0;
                end
            end
            S_WAIT: begin
                if (imem_ready) begin
                    state_d = S_RUN;
                    wait_d  = '0;
                end else if (wait_q == WAIT_MAX) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + WCW'(1);
                end
            end
            S_FAULT: begin
                // Terminal until reset; hold the pipeline frozen with bubbles.
                wpcir     = 1'b0;
                id_bubble = 1'b1;
                if_flush  = 1'b0;
            end
            default: begin
                state_d = S_RUN;
                wait_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= S_RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            stall_q <= '0;
        end else if (!wpcir && state_q != S_FAULT && stall_q != {CNT_W{1'b1}}) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign stall_count = stall_q;
    assign state       = state_q;
    assign fault       = (state_q == S_FAULT);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        clrn;
    logic [4:0]  id_rs, id_rt, ex_rn;
    logic        id_use_rs, id_use_rt, ex_wreg, ex_m2reg, br_taken, imem_ready;
    logic        wpcir, if_flush, id_bubble, fault;
    logic [15:0] stall_count;
    logic [1:0]  state;
    logic        s_wpcir, s_if_flush, s_id_bubble, s_fault;
    logic [1:0]  s_stall_count;
    logic [1:0]  s_state;

    int vectors;
    int miscompares;

    pipe_hazard_ctrl dut (
        .clk         (clk),
        .clrn        (clrn),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .ex_rn       (ex_rn),
        .ex_wreg     (ex_wreg),
        .ex_m2reg    (ex_m2reg),
        .br_taken    (br_taken),
        .imem_ready  (imem_ready),
        .wpcir       (wpcir),
        .if_flush    (if_flush),
        .id_bubble   (id_bubble),
        .fault       (fault),
        .stall_count (stall_count),
        .state       (state)
    );

    // Narrow-counter instance so saturation is reachable in a few cycles.
    pipe_hazard_ctrl #(.WAIT_LIMIT(15), .CNT_W(2)) dut_sat (
        .clk         (clk),
        .clrn        (clrn),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .ex_rn       (ex_rn),
        .ex_wreg     (ex_wreg),
        .ex_m2reg    (ex_m2reg),
        .br_taken    (br_taken),
        .imem_ready  (imem_ready),
        .wpcir       (s_wpcir),
        .if_flush    (s_if_flush),
        .id_bubble   (s_id_bubble),
        .fault       (s_fault),
        .stall_count (s_stall_count),
        .state       (s_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        ex_rn = 5'd0; ex_wreg = 1'b0; ex_m2reg = 1'b0;
        br_taken = 1'b0; imem_ready = 1'b1;
    endtask

    task automatic pulse_reset();
        #2 clrn = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_count", 32'(stall_count), 32'd0);
        #1 clrn = 1'b1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        clrn = 1'b0;
        idle_inputs();

        // Reset state and combinational outputs during reset
        #2;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_fault", 32'(fault), 32'd0);
        chk("reset_count", 32'(stall_count), 32'd0);
        chk("reset_wpcir", 32'(wpcir), 32'd1);
        chk("reset_bubble", 32'(id_bubble), 32'd0);
        ex_m2reg = 1'b1; ex_wreg = 1'b1; ex_rn = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
        #1;
        chk("reset_lu_wpcir", 32'(wpcir), 32'd0);
        idle_inputs();
        #9 clrn = 1'b1;
        step();

        // Load to r0 is never a hazard
        ex_m2reg = 1'b1; ex_wreg = 1'b1; ex_rn = 5'd0; id_rs = 5'd5; id_use_rs = 1'b1;
        #1;
        chk("r0_wpcir", 32'(wpcir), 32'd1);
        chk("r0_bubble", 32'(id_bubble), 32'd0);
        step();
        chk("r0_state", 32'(state), 32'd0);
        chk("r0_count", 32'(stall_count), 32'd0);

        // Load-use on rs
        ex_rn = 5'd5;
        #1;
        chk("lu_rs_wpcir", 32'(wpcir), 32'd0);
        chk("lu_rs_bubble", 32'(id_bubble), 32'd1);
        chk("lu_rs_flush", 32'(if_flush), 32'd0);
        step();
        chk("lu_rs_state", 32'(state), 32'd1);
        chk("lu_rs_count", 32'(stall_count), 32'd1);

        // Load-use on rt, then rt not used, then non-writing match
        id_use_rs = 1'b0; id_rs = 5'd7; id_use_rt = 1'b1; id_rt = 5'd5;
        #1;
        chk("lu_rt_wpcir", 32'(wpcir), 32'd0);
        id_use_rt = 1'b0;
        #1;
        chk("rt_unused_wpcir", 32'(wpcir), 32'd1);
        id_use_rt = 1'b1; ex_wreg = 1'b0;
        #1;
        chk("nowreg_wpcir", 32'(wpcir), 32'd1);
        ex_wreg = 1'b1; ex_m2reg = 1'b0;
        #1;
        chk("noload_bubble", 32'(id_bubble), 32'd0);
        step();
        chk("stall_exit_state", 32'(state), 32'd0);
        chk("stall_exit_count", 32'(stall_count), 32'd1);

        // Branch flush, and branch ignored under load-use
        idle_inputs();
        br_taken = 1'b1;
        #1;
        chk("br_flush", 32'(if_flush), 32'd1);
        chk("br_wpcir", 32'(wpcir), 32'd1);
        ex_m2reg = 1'b1; ex_wreg = 1'b1; ex_rn = 5'd9; id_rt = 5'd9; id_use_rt = 1'b1;
        #1;
        chk("br_lu_flush", 32'(if_flush), 32'd0);
        chk("br_lu_wpcir", 32'(wpcir), 32'd0);
        idle_inputs();
        br_taken = 1'b1; imem_ready = 1'b0;
        #1;
        chk("br_wait_flush", 32'(if_flush), 32'd0);
        chk("wait_bubble", 32'(id_bubble), 32'd1);
        idle_inputs();

        // 15 not-ready cycles then ready: back to RUN
        pulse_reset();
        step();
        imem_ready = 1'b0;
        step();
        chk("wait_enter_state", 32'(state), 32'd2);
        for (int i = 1; i < 15; i++) step();
        chk("wait15_state", 32'(state), 32'd2);
        chk("wait15_fault", 32'(fault), 32'd0);
        imem_ready = 1'b1;
        step();
        chk("wait_exit_state", 32'(state), 32'd0);
        chk("wait_exit_fault", 32'(fault), 32'd0);
        chk("wait_exit_count", 32'(stall_count), 32'd15);

        // 16 not-ready cycles: fault, frozen outputs, no counting
        pulse_reset();
        step();
        imem_ready = 1'b0;
        for (int i = 0; i < 16; i++) step();
        chk("fault_state", 32'(state), 32'd3);
        chk("fault_flag", 32'(fault), 32'd1);
        chk("fault_wpcir", 32'(wpcir), 32'd0);
        chk("fault_count", 32'(stall_count), 32'd16);
        imem_ready = 1'b1; br_taken = 1'b1;
        #1;
        chk("fault_ready_wpcir", 32'(wpcir), 32'd0);
        chk("fault_ready_bubble", 32'(id_bubble), 32'd1);
        chk("fault_ready_flush", 32'(if_flush), 32'd0);
        step();
        chk("fault_sticky", 32'(state), 32'd3);
        chk("fault_nocount", 32'(stall_count), 32'd16);
        br_taken = 1'b0;
        pulse_reset();
        chk("post_fault_wpcir", 32'(wpcir), 32'd1);
        step();
        chk("post_fault_state", 32'(state), 32'd0);

        // Reset mid-WAIT restarts the timeout from zero
        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("midwait_state", 32'(state), 32'd2);
        pulse_reset();
        chk("midwait_rst_state", 32'(state), 32'd0);
        for (int i = 0; i < 15; i++) step();
        chk("midwait_15_state", 32'(state), 32'd2);
        step();
        chk("midwait_16_state", 32'(state), 32'd3);
        imem_ready = 1'b1;
        pulse_reset();
        step();

        // Saturation on the 2-bit counter instance
        ex_m2reg = 1'b1; ex_wreg = 1'b1; ex_rn = 5'd3; id_rs = 5'd3; id_use_rs = 1'b1;
        step();
        step();
        chk("sat_pre", 32'(s_stall_count), 32'd2);
        for (int i = 0; i < 3; i++) step();
        chk("sat_hold", 32'(s_stall_count), 32'd3);
        chk("sat_main_count", 32'(stall_count), 32'd5);
        chk("sat_state", 32'(state), 32'd1);
        idle_inputs();
        step();
        chk("sat_keep", 32'(s_stall_count), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
